// File: rtl/v_issue_ctrl_pkg.sv
// rtl/v_issue_ctrl_pkg.sv - shared types for the vector issue controller
package v_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    VU_ALU  = 3'd0,
    VU_MUL  = 3'd1,
    VU_RED  = 3'd2,
    VU_SLDU = 3'd3,
    VU_LSU  = 3'd4,
    VU_NOP  = 3'd5
  } vunit_e;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_VREG = 2'd1,
    WB_XREG = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } issue_state_e;

  // unit stays raw so illegal codes 6-7 survive the trip through the FIFO
  typedef struct packed {
    logic [2:0] unit;
    logic [4:0] vd;
    wb_sel_e    wb_sel;
  } issue_op_t;

endpackage

// File: rtl/v_issue_fifo.sv
// rtl/v_issue_fifo.sv - synchronous FIFO of decoded issue ops
module v_issue_fifo
  import v_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  issue_op_t     push_data,
  input  logic          pop,
  output issue_op_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  issue_op_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // full is judged on the registered count, so a same-cycle pop never frees a slot
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/v_issue_ctrl.sv
// rtl/v_issue_ctrl.sv - issues buffered vector ops one at a time and sequences writeback
module v_issue_ctrl
  import v_issue_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_unit,
  input  logic [4:0]                    in_vd,
  input  logic [1:0]                    in_wb_sel,
  output logic [4:0]                    start,
  input  logic [4:0]                    done,
  output logic                          v_reg_wr_en,
  output logic                          x_reg_wr_en,
  output logic [4:0]                    wb_vd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_timeout,
  output logic                          err_illegal,
  input  logic                          err_clr
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  issue_state_e   state;
  issue_state_e   next_state;
  issue_op_t      in_op;
  issue_op_t      head;
  issue_op_t      op_q;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic [WDW-1:0] wdog;
  logic           wd_clr;
  logic           set_timeout;
  logic           set_illegal;
  logic [4:0]     unit_mask;

  assign in_op = '{unit: in_unit, vd: in_vd, wb_sel: wb_sel_e'(in_wb_sel)};

  v_issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (in_valid),
    .push_data (in_op),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;

  // zero for NOP and illegal codes, so neither can start a unit or match a done bit
  assign unit_mask = (op_q.unit <= VU_LSU) ? (5'b00001 << op_q.unit) : 5'b00000;

  always_comb begin
    next_state  = state;
    pop         = 1'b0;
    start       = '0;
    v_reg_wr_en = 1'b0;
    x_reg_wr_en = 1'b0;
    wd_clr      = 1'b0;
    set_timeout = 1'b0;
    set_illegal = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        wd_clr = 1'b1;
        if (op_q.unit == VU_NOP) begin
          next_state = WB;
        end else if (unit_mask != '0) begin
          start      = unit_mask;
          next_state = WAIT;
        end else begin
          set_illegal = 1'b1;
          next_state  = IDLE;
        end
      end
      WAIT: begin
        if ((done & unit_mask) != '0) begin
          next_state = WB;
        end else if (wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
          set_timeout = 1'b1;
          next_state  = IDLE;
        end
      end
      WB: begin
        v_reg_wr_en = (op_q.wb_sel == WB_VREG);
        x_reg_wr_en = (op_q.wb_sel == WB_XREG);
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state       <= IDLE;
      op_q        <= '0;
      wdog        <= '0;
      wb_vd       <= '0;
      err_timeout <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (pop) op_q <= head;
      if (wd_clr)             wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 1'b1;
      // captured on entry to WB so it is valid alongside the write pulse and held afterwards
      if (next_state == WB) wb_vd <= op_q.vd;
      if (set_timeout)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (set_illegal)  err_illegal <= 1'b1;
      else if (err_clr) err_illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_v_issue_ctrl.sv
// tb/tb_v_issue_ctrl.sv - self-checking bench for v_issue_ctrl
module tb_v_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int T     = 8;
  localparam int MAXC  = 1000;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       in_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] in_unit = '0;
  logic [4:0] in_vd = '0;
  logic [1:0] in_wb_sel = '0;
  logic [4:0] done = '0;
  logic       in_ready, v_reg_wr_en, x_reg_wr_en, busy, err_timeout, err_illegal;
  logic [4:0] start, wb_vd;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int free_c = 0;

  // per-cycle expectations, filled in when each op is accepted
  logic [4:0] start_exp [MAXC];
  logic [4:0] done_plan [MAXC];
  logic [4:0] vd_exp    [MAXC];
  int         cnt_exp   [MAXC];
  bit         v_exp     [MAXC];
  bit         x_exp     [MAXC];
  bit         busy_f    [MAXC];
  bit         ill_set   [MAXC];
  bit         tmo_set   [MAXC];
  bit         clr_ev    [MAXC];
  bit         rst_mark  [MAXC];
  bit         exp_ill = 1'b0;
  bit         exp_tmo = 1'b0;

  v_issue_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_unit     (in_unit),
    .in_vd       (in_vd),
    .in_wb_sel   (in_wb_sel),
    .start       (start),
    .done        (done),
    .v_reg_wr_en (v_reg_wr_en),
    .x_reg_wr_en (x_reg_wr_en),
    .wb_vd       (wb_vd),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .err_timeout (err_timeout),
    .err_illegal (err_illegal),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int r);
    for (int j = r; j < MAXC; j++) begin
      start_exp[j] = '0; done_plan[j] = '0; vd_exp[j] = '0; cnt_exp[j] = 0;
      v_exp[j] = 0; x_exp[j] = 0; busy_f[j] = 0; ill_set[j] = 0;
      tmo_set[j] = 0; clr_ev[j] = 0; rst_mark[j] = 0;
    end
    rst_mark[r] = 1'b1;
    free_c = r;
  endtask

  // Op enters the FIFO at edge e, pops from IDLE cycle p, starts in cycle s=p+1.
  // The unit answers d cycles after start (d outside 1..T means never).
  task automatic sched(input int e, input logic [2:0] u, input logic [4:0] vd,
                       input logic [1:0] wb, input int d, input logic [4:0] noise,
                       output int s);
    int p, w, last;
    logic [4:0] own;
    p = (e > free_c) ? e : free_c;
    s = p + 1;
    w = -1;
    own = 5'b00001 << u;
    for (int j = e; j < MAXC; j++) cnt_exp[j]++;
    for (int j = s; j < MAXC; j++) cnt_exp[j]--;
    if (u <= 3'd4) begin
      start_exp[s] = own;
      done_plan[s] |= noise;
      done_plan[s+2] |= noise & ~own;
      if (d >= 1 && d <= T) begin
        done_plan[s+d] |= own;
        w = s + d + 1;
        last = w;
      end else begin
        last = s + T;
        tmo_set[s+T+1] = 1'b1;
      end
    end else if (u == 3'd5) begin
      w = s + 1;
      last = w;
    end else begin
      last = s;
      ill_set[s+1] = 1'b1;
    end
    if (w >= 0) begin
      v_exp[w] = (wb == 2'd1);
      x_exp[w] = (wb == 2'd2);
      for (int j = w; j < MAXC; j++) vd_exp[j] = vd;
    end
    for (int j = s; j <= last; j++) busy_f[j] = 1'b1;
    free_c = last + 1;
  endtask

  task automatic push_op(input logic [2:0] u, input logic [4:0] vd, input logic [1:0] wb,
                         input int d, input logic [4:0] noise, output int s);
    bit ok;
    ok = 1'b0;
    s = 0;
    in_valid = 1'b1; in_unit = u; in_vd = vd; in_wb_sel = wb;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (cnt_exp[cyc] < DEPTH) begin
        sched(cyc + 1, u, vd, wb, d, noise, s);
        ok = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    clr_ev[cyc+1] = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    model_reset(cyc + 1);
    step();
    nrst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      done = (cyc < MAXC) ? done_plan[cyc] : 5'b00000;
    end
  end

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (rst_mark[cyc]) begin
        exp_ill = 1'b0;
        exp_tmo = 1'b0;
      end else begin
        if (ill_set[cyc])     exp_ill = 1'b1;
        else if (clr_ev[cyc]) exp_ill = 1'b0;
        if (tmo_set[cyc])     exp_tmo = 1'b1;
        else if (clr_ev[cyc]) exp_tmo = 1'b0;
      end
      if (chk_en) begin
        chk("start", 32'(start), 32'(start_exp[cyc]));
        chk("v_reg_wr_en", 32'(v_reg_wr_en), 32'(v_exp[cyc]));
        chk("x_reg_wr_en", 32'(x_reg_wr_en), 32'(x_exp[cyc]));
        chk("wb_vd", 32'(wb_vd), 32'(vd_exp[cyc]));
        chk("fifo_count", 32'(fifo_count), 32'(cnt_exp[cyc]));
        chk("in_ready", 32'(in_ready), 32'(cnt_exp[cyc] < DEPTH));
        chk("busy", 32'(busy), 32'(busy_f[cyc] || cnt_exp[cyc] != 0));
        chk("err_illegal", 32'(err_illegal), 32'(exp_ill));
        chk("err_timeout", 32'(err_timeout), 32'(exp_tmo));
      end
    end
  end

  initial begin
    int s, s1, s2, s3;
    model_reset(0);
    step();
    do_reset();
    chk_en = 1'b1;
    idle(2);

    // single VALU op, unit answers one cycle after start
    push_op(3'd0, 5'd7, 2'd1, 1, 5'b00000, s);
    step();
    chk("t2_start", 32'(start), 32'h01);
    step();
    chk("t2_no_wr_yet", 32'(v_reg_wr_en), 32'd0);
    step();
    chk("t2_v_wr", 32'(v_reg_wr_en), 32'd1);
    chk("t2_x_wr", 32'(x_reg_wr_en), 32'd0);
    chk("t2_wb_vd", 32'(wb_vd), 32'd7);
    step();
    chk("t2_v_wr_drop", 32'(v_reg_wr_en), 32'd0);
    idle(3);

    // back-pressure: stalled first op lets the FIFO fill, sixth op waits
    push_op(3'd1, 5'd1, 2'd1, T, 5'b00000, s);
    push_op(3'd0, 5'd2, 2'd2, 1, 5'b00000, s);
    push_op(3'd4, 5'd3, 2'd1, 3, 5'b00000, s);
    push_op(3'd3, 5'd4, 2'd0, 2, 5'b00000, s);
    push_op(3'd2, 5'd5, 2'd3, 1, 5'b00000, s);
    chk("t3_full_count", 32'(fifo_count), 32'd4);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    push_op(3'd1, 5'd6, 2'd1, 2, 5'b00000, s);
    idle(40);
    chk("t3_last_vd", 32'(wb_vd), 32'd6);

    // VRED never answers while other units chatter; next op still issues
    push_op(3'd2, 5'd9, 2'd2, 100, 5'b01101, s);
    push_op(3'd1, 5'd10, 2'd1, 2, 5'b00000, s);
    idle(20);
    chk("t4_err_timeout", 32'(err_timeout), 32'd1);
    chk("t4_next_vd", 32'(wb_vd), 32'd10);
    pulse_clr();
    chk("t4_cleared", 32'(err_timeout), 32'd0);
    idle(2);

    // done lands on the last watchdog cycle: completion wins
    push_op(3'd3, 5'd11, 2'd1, T, 5'b00000, s);
    idle(15);
    chk("t6_no_timeout", 32'(err_timeout), 32'd0);
    chk("t6_wb_vd", 32'(wb_vd), 32'd11);

    // illegal code then NOP
    push_op(3'd6, 5'd12, 2'd1, 1, 5'b00000, s1);
    push_op(3'd5, 5'd13, 2'd0, 0, 5'b00000, s2);
    idle(6);
    chk("t5_err_illegal", 32'(err_illegal), 32'd1);
    chk("t5_nop_vd", 32'(wb_vd), 32'd13);
    pulse_clr();
    chk("t5_cleared", 32'(err_illegal), 32'd0);
    push_op(3'd7, 5'd14, 2'd1, 0, 5'b00000, s3);
    for (int i = 0; i < 20 && cyc < s3; i++) step();
    err_clr = 1'b1;
    clr_ev[cyc+1] = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t5_set_beats_clr", 32'(err_illegal), 32'd1);
    idle(4);

    // reset with one op in WAIT and two queued
    push_op(3'd1, 5'd20, 2'd1, T, 5'b00000, s);
    push_op(3'd0, 5'd21, 2'd1, 1, 5'b00000, s);
    push_op(3'd4, 5'd22, 2'd2, 1, 5'b00000, s);
    idle(2);
    do_reset();
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_start", 32'(start), 32'd0);
    chk("t1_count", 32'(fifo_count), 32'd0);
    chk("t1_ready", 32'(in_ready), 32'd1);
    chk("t1_err_illegal", 32'(err_illegal), 32'd0);
    idle(15);

    // normal operation resumes after reset
    push_op(3'd4, 5'd23, 2'd2, 2, 5'b00000, s);
    idle(10);
    chk("t1_resume_vd", 32'(wb_vd), 32'd23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
